wishbone_slave_regbank: RTL and testbench

//  Wishbone slave register bank. It responds to wishbone_master bus cycles (stb/cyc/we/sel/ack) on the peripheral bus.
//  It provides a control register, a status register, NUM_REGS scratch registers, programmable wait states and a level interrupt.
//  It is the reference responder for bus bring-up and master verification.

---
 rtl/wishbone_slave_regbank.sv | 185 ++++++++++++++++++
 tb/tb_wishbone_slave_regbank.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_slave_regbank.sv
// Wishbone slave register bank: control, status, scratch registers,
// programmable wait states and a level interrupt for bus bring-up.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   wbs_adr_i     word address, only [7:0] decoded
//   wbs_dat_i     write data
//   wbs_dat_o     read data, valid with wbs_ack_o
//   wbs_stb_i     strobe
//   wbs_cyc_i     cycle valid
//   wbs_we_i      1 = write, 0 = read
//   wbs_msk_i     reserved, ignored
//   wbs_sel_i     byte lane enables
//   wbs_ack_o     single-cycle acknowledge
//   wbs_int_o     interrupt level (pending & enable)
//
// Build option: define WBS_BYTE_SEL_EN to honour wbs_sel_i on writes.
// Without it every write updates the whole word.

module wishbone_slave_regbank #(
   parameter int NUM_REGS    = 4,
   parameter int WAIT_STATES = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic [31:0] wbs_dat_o,
   input  logic        wbs_stb_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_we_i,
   input  logic        wbs_msk_i,
   input  logic [3:0]  wbs_sel_i,
   output logic        wbs_ack_o,
   output logic        wbs_int_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ACK,
      S_REL
   } state_t;

   localparam bit         NO_WAIT = (WAIT_STATES == 0);
   localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

   state_t      state;
   logic [3:0]  wait_cnt;
   logic [31:0] scr [NUM_REGS];
   logic        int_enable;
   logic        int_pending;
   logic [15:0] wr_count;

   logic [7:0]  adr;
   logic        go;
   logic        commit;
   logic        is_ctrl;
   logic        scr_hit;
   logic        lane_ok;
   logic        ctrl_ok;
   logic [31:0] rd_data;
   logic [31:0] byte_mask;
   logic        unused_ok;

   assign adr     = wbs_adr_i[7:0];
   assign go      = wbs_stb_i & wbs_cyc_i;
   assign is_ctrl = (adr == 8'h00);

   // The access is performed on the edge that enters ACK, using the
   // bus values present on that edge.
   assign commit = go & ((state == S_IDLE && NO_WAIT) |
                         (state == S_WAIT && wait_cnt == 4'd1));

`ifdef WBS_BYTE_SEL_EN
   assign byte_mask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                       {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
   assign lane_ok   = |wbs_sel_i;
   assign ctrl_ok   = wbs_sel_i[0];
   assign unused_ok = ^{wbs_msk_i, wbs_adr_i[31:8]};
`else
   assign byte_mask = '1;
   assign lane_ok   = 1'b1;
   assign ctrl_ok   = 1'b1;
   assign unused_ok = ^{wbs_msk_i, wbs_sel_i, wbs_adr_i[31:8]};
`endif

   always_comb begin
      rd_data = '0;
      scr_hit = 1'b0;
      if (adr == 8'h00) begin
         rd_data = {31'b0, int_enable};
      end else if (adr == 8'h01) begin
         rd_data = {int_pending, 15'b0, wr_count};
      end
      for (int i = 0; i < NUM_REGS; i++) begin
         if (adr == 8'(i + 2)) begin
            rd_data = scr[i];
            scr_hit = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         wait_cnt    <= '0;
         wbs_ack_o   <= 1'b0;
         wbs_dat_o   <= '0;
         wbs_int_o   <= 1'b0;
         int_enable  <= 1'b0;
         int_pending <= 1'b0;
         wr_count    <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            scr[i] <= '0;
         end
      end else begin
         wbs_ack_o <= 1'b0;
         // Interrupt is a registered copy, one cycle behind pending.
         wbs_int_o <= int_pending & int_enable;

         unique case (state)
            S_IDLE: begin
               if (go) begin
                  if (NO_WAIT) begin
                     state <= S_ACK;
                  end else begin
                     wait_cnt <= WS_LOAD;
                     state    <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               // Master abort: drop back without ack or update.
               if (!go) begin
                  state <= S_IDLE;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
                  if (wait_cnt == 4'd1) begin
                     state <= S_ACK;
                  end
               end
            end
            S_ACK: begin
               state <= S_REL;
            end
            S_REL: begin
               // Hold off until strobe drops so one request
               // is never acked twice.
               if (!wbs_stb_i) begin
                  state <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase

         if (commit) begin
            wbs_ack_o <= 1'b1;
            wbs_dat_o <= wbs_we_i ? '0 : rd_data;
            if (wbs_we_i && is_ctrl && ctrl_ok) begin
               int_enable <= wbs_dat_i[0];
               if (wbs_dat_i[1]) begin
                  int_pending <= 1'b0;
               end
            end
            // Placed after the clear so a coincident set wins.
            if (wbs_we_i && scr_hit && lane_ok) begin
               for (int i = 0; i < NUM_REGS; i++) begin
                  if (adr == 8'(i + 2)) begin
                     scr[i] <= (scr[i] & ~byte_mask) |
                               (wbs_dat_i & byte_mask);
                  end
               end
               wr_count <= wr_count + 16'd1;
               if (int_enable) begin
                  int_pending <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_wishbone_slave_regbank.sv
// Bench for wishbone_slave_regbank: two instances (no wait states with
// four scratch registers, three wait states with one scratch register).

module tb_wishbone_slave_regbank;

   localparam int WS0 = 0;
   localparam int WS1 = 3;
   localparam int NR0 = 4;
   localparam int NR1 = 1;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] adr  [2];
   logic [31:0] wdat [2];
   logic [31:0] rdat [2];
   logic        stb  [2];
   logic        cyc  [2];
   logic        we   [2];
   logic        msk  [2];
   logic [3:0]  sel  [2];
   logic        ack  [2];
   logic        irq  [2];

   always #5 clk = ~clk;

   wishbone_slave_regbank #(.NUM_REGS(NR0), .WAIT_STATES(WS0)) u0 (
      .clk(clk), .rst(rst),
      .wbs_adr_i(adr[0]), .wbs_dat_i(wdat[0]), .wbs_dat_o(rdat[0]),
      .wbs_stb_i(stb[0]), .wbs_cyc_i(cyc[0]), .wbs_we_i(we[0]),
      .wbs_msk_i(msk[0]), .wbs_sel_i(sel[0]),
      .wbs_ack_o(ack[0]), .wbs_int_o(irq[0])
   );

   wishbone_slave_regbank #(.NUM_REGS(NR1), .WAIT_STATES(WS1)) u1 (
      .clk(clk), .rst(rst),
      .wbs_adr_i(adr[1]), .wbs_dat_i(wdat[1]), .wbs_dat_o(rdat[1]),
      .wbs_stb_i(stb[1]), .wbs_cyc_i(cyc[1]), .wbs_we_i(we[1]),
      .wbs_msk_i(msk[1]), .wbs_sel_i(sel[1]),
      .wbs_ack_o(ack[1]), .wbs_int_o(irq[1])
   );

   // Reference model: register contents per instance.
   logic [31:0] m_scr  [2][64];
   bit          m_en   [2];
   bit          m_pend [2];
   logic [15:0] m_cnt  [2];

   logic        exp_ack [2];
   logic        exp_irq [2];
   logic [31:0] exp_dat [2];

   bit chk_on = 1'b0;
   int checks = 0;
   int failures = 0;

   function automatic int ws(int d);
      return (d == 0) ? WS0 : WS1;
   endfunction

   function automatic int nr(int d);
      return (d == 0) ? NR0 : NR1;
   endfunction

   function automatic void chk(string nm, logic [31:0] got,
                               logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, got, exp);
      end
   endfunction

   function automatic logic [31:0] m_read(int d, logic [7:0] a);
      int ai = int'(a);
      if (ai == 0) return {31'b0, m_en[d]};
      if (ai == 1) return {m_pend[d], 15'b0, m_cnt[d]};
      if (ai >= 2 && ai < 2 + nr(d)) return m_scr[d][ai - 2];
      return 32'h0;
   endfunction

   function automatic void m_write(int d, logic [7:0] a,
                                   logic [31:0] wd, logic [3:0] s);
      logic [31:0] m;
      bit bse;
      int ai = int'(a);
`ifdef WBS_BYTE_SEL_EN
      bse = 1'b1;
`else
      bse = 1'b0;
`endif
      m = bse ? {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}}
              : 32'hFFFF_FFFF;
      if (ai == 0) begin
         if (!bse || s[0]) begin
            if (wd[1]) m_pend[d] = 1'b0;
            m_en[d] = wd[0];
         end
      end else if (ai >= 2 && ai < 2 + nr(d)) begin
         if (!bse || s != 4'h0) begin
            m_scr[d][ai - 2] = (m_scr[d][ai - 2] & ~m) | (wd & m);
            m_cnt[d] = m_cnt[d] + 16'd1;
            if (m_en[d]) m_pend[d] = 1'b1;
         end
      end
   endfunction

   // Single compare process: every output of both instances, every cycle.
   always @(negedge clk) begin
      if (chk_on) begin
         for (int d = 0; d < 2; d++) begin
            chk($sformatf("ack%0d", d), {31'b0, ack[d]},
                {31'b0, exp_ack[d]});
            chk($sformatf("int%0d", d), {31'b0, irq[d]},
                {31'b0, exp_irq[d]});
            chk($sformatf("dat%0d", d), rdat[d], exp_dat[d]);
         end
      end
   end

   // One clock edge; cd names the instance whose access lands on it.
   task automatic tick(input int cd);
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         exp_irq[d] = m_pend[d] & m_en[d];
         exp_ack[d] = 1'b0;
      end
      if (cd >= 0) begin
         exp_ack[cd] = 1'b1;
         exp_dat[cd] = we[cd] ? 32'h0 : m_read(cd, adr[cd][7:0]);
         if (we[cd]) m_write(cd, adr[cd][7:0], wdat[cd], sel[cd]);
      end
   endtask

   task automatic do_reset(input bit keep);
      if (!keep) begin
         for (int d = 0; d < 2; d++) begin
            stb[d] = 1'b0;
            cyc[d] = 1'b0;
         end
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         m_en[d] = 1'b0;
         m_pend[d] = 1'b0;
         m_cnt[d] = 16'h0;
         for (int k = 0; k < 64; k++) m_scr[d][k] = 32'h0;
         exp_ack[d] = 1'b0;
         exp_irq[d] = 1'b0;
         exp_dat[d] = 32'h0;
         stb[d] = 1'b0;
         cyc[d] = 1'b0;
      end
      chk_on = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // drop >= 1 lowers stb/cyc before that edge (abort in WAIT);
   // hold = extra edges stb stays high after the ack.
   task automatic txn(input int d, input bit w, input logic [7:0] a,
                      input logic [31:0] wd, input logic [3:0] s,
                      input int drop, input int hold,
                      output logic [31:0] rd);
      logic [31:0] hi;
      hi = $urandom();
      adr[d]  = {hi[31:8], a};
      wdat[d] = wd;
      we[d]   = w;
      sel[d]  = s;
      msk[d]  = hi[0];
      stb[d]  = 1'b1;
      cyc[d]  = 1'b1;
      rd = 32'h0;
      for (int n = 0; n <= ws(d); n++) begin
         if (drop >= 1 && n == drop) begin
            if ($urandom_range(1) == 1) stb[d] = 1'b0;
            else cyc[d] = 1'b0;
            tick(-1);
            stb[d] = 1'b0;
            cyc[d] = 1'b0;
            return;
         end
         tick((n == ws(d)) ? d : -1);
      end
      rd = rdat[d];
      repeat (hold) tick(-1);
      stb[d] = 1'b0;
      cyc[d] = 1'b0;
      tick(-1);
      if (hold == 0) tick(-1);
   endtask

   // Idle cycles with lone stb or lone cyc, which must not start a cycle.
   task automatic gap(input int d, input int n);
      for (int i = 0; i < n; i++) begin
         case ($urandom_range(2))
            1: begin stb[d] = 1'b1; cyc[d] = 1'b0; end
            2: begin stb[d] = 1'b0; cyc[d] = 1'b1; end
            default: begin stb[d] = 1'b0; cyc[d] = 1'b0; end
         endcase
         tick(-1);
      end
      stb[d] = 1'b0;
      cyc[d] = 1'b0;
   endtask

   logic [31:0] rv;
   logic [31:0] exp6;

   initial begin
      rst = 1'b0;
      for (int d = 0; d < 2; d++) begin
         adr[d] = 32'h0; wdat[d] = 32'h0; we[d] = 1'b0;
         stb[d] = 1'b0; cyc[d] = 1'b0; msk[d] = 1'b0; sel[d] = 4'h0;
      end
      do_reset(1'b0);
      chk("reset_dat0", rdat[0], 32'h0);
      chk("reset_int1", {31'b0, irq[1]}, 32'h0);

      // Write then read back, no wait states.
      txn(0, 1'b1, 8'h02, 32'hCAFEBABE, 4'hF, 0, 1, rv);
      txn(0, 1'b0, 8'h02, 32'h0, 4'hF, 0, 1, rv);
      chk("t1_read", rv, 32'hCAFEBABE);
      txn(0, 1'b0, 8'h01, 32'h0, 4'hF, 0, 0, rv);
      chk("t1_status", rv, 32'h0000_0001);

      // Three wait states, strobe held one extra cycle.
      txn(1, 1'b0, 8'h01, 32'h0, 4'hF, 0, 1, rv);
      chk("t2_status", rv, 32'h0);

      // Interrupt set and clear.
      txn(0, 1'b1, 8'h00, 32'h1, 4'hF, 0, 1, rv);
      txn(0, 1'b1, 8'h03, 32'h5, 4'hF, 0, 1, rv);
      chk("t3_int_on", {31'b0, irq[0]}, 32'h1);
      txn(0, 1'b1, 8'h00, 32'h3, 4'hF, 0, 1, rv);
      chk("t3_int_off", {31'b0, irq[0]}, 32'h0);
      txn(0, 1'b0, 8'h01, 32'h0, 4'hF, 0, 1, rv);
      chk("t3_status", rv, 32'h0000_0002);

      // Master abort after one wait cycle.
      txn(1, 1'b1, 8'h02, 32'h11, 4'hF, 0, 0, rv);
      txn(1, 1'b1, 8'h02, 32'hDEAD, 4'hF, 1, 0, rv);
      txn(1, 1'b0, 8'h02, 32'h0, 4'hF, 0, 2, rv);
      chk("t4_unchanged", rv, 32'h11);

      // Unmapped address.
      txn(0, 1'b1, 8'h7F, 32'h1, 4'hF, 0, 1, rv);
      txn(0, 1'b0, 8'h7F, 32'h0, 4'hF, 0, 1, rv);
      chk("t5_unmapped", rv, 32'h0);
      txn(0, 1'b0, 8'h01, 32'h0, 4'hF, 0, 1, rv);
      chk("t5_count", rv, 32'h0000_0002);

      // Byte lanes.
      txn(0, 1'b1, 8'h02, 32'hFFFFFFFF, 4'hF, 0, 1, rv);
      txn(0, 1'b1, 8'h02, 32'h0, 4'b0101, 0, 1, rv);
      txn(0, 1'b0, 8'h02, 32'h0, 4'hF, 0, 1, rv);
`ifdef WBS_BYTE_SEL_EN
      exp6 = 32'hFF00FF00;
`else
      exp6 = 32'h0;
`endif
      chk("t6_bytesel", rv, exp6);

      // Reset on the edge that would have committed a write.
      txn(1, 1'b1, 8'h02, 32'h55, 4'hF, 0, 1, rv);
      adr[1] = 32'h2; wdat[1] = 32'h99; we[1] = 1'b1; sel[1] = 4'hF;
      stb[1] = 1'b1; cyc[1] = 1'b1;
      tick(-1);
      tick(-1);
      tick(-1);
      do_reset(1'b1);
      txn(1, 1'b0, 8'h02, 32'h0, 4'hF, 0, 1, rv);
      chk("t7_no_commit", rv, 32'h0);

      // Randomized traffic on both instances.
      for (int it = 0; it < 300; it++) begin
         int d;
         int r;
         int drop;
         logic [7:0] a;
         logic [31:0] wd;
         logic [3:0] s;
         d = $urandom_range(1);
         r = $urandom_range(9);
         a = (r < 6) ? 8'(r) : 8'($urandom_range(255));
         wd = $urandom();
         s = ($urandom_range(5) == 0) ? 4'h0 : 4'($urandom_range(15));
         drop = 0;
         if (ws(d) > 0 && $urandom_range(7) == 0)
            drop = $urandom_range(ws(d), 1);
         txn(d, 1'($urandom_range(1)), a, wd, s, drop,
             $urandom_range(2), rv);
         gap(d, $urandom_range(2));
      end

      tick(-1);
      tick(-1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
